// File: rtl/shiftreg_pkg.sv
// Shared constants and types for the shift-line scheduler.
package shiftreg_pkg;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   localparam int SR_DEPTH = 20;
   localparam int SR_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } sched_state_e;

endpackage

// File: rtl/shiftreg_sched_rr_arb2.sv
// Two-request round-robin arbiter; the pointer names the source preferred on a tie.
module rr_arb2
   import shiftreg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic ptr_q;
   logic ptr_d;

   // Grant the lone requester, or the preferred one when both request.
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = (ptr_q == SRC_B) ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

   // Pointer moves to the other source only when a grant is actually consumed.
   always_comb begin
      ptr_d = ptr_q;
      if (advance && (gnt != 2'b00)) begin
         ptr_d = gnt[0] ? SRC_B : SRC_A;
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= SRC_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/shiftreg_sched.sv
// Scheduler for a shared DEPTH-stage byte shift line: arbitrates sources A/B,
// tracks per-stage valid/source tags and presents the tail as a stream.
module shiftreg_sched
   import shiftreg_pkg::*;
#(
   parameter  int DEPTH = SR_DEPTH,
   parameter  int WIDTH = SR_WIDTH,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   input  logic             flush,
   output logic             sr_shift_en,
   output logic [WIDTH-1:0] sr_data_in,
   input  logic [WIDTH-1:0] sr_data_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic [CW-1:0]    occupancy,
   output logic             busy
);

   sched_state_e     state_q, state_d;
   logic [DEPTH-1:0] tv_q, tv_d;
   logic [DEPTH-1:0] ts_q, ts_d;
   logic [CW-1:0]    occ_q, occ_d;

   logic       shift_ok;
   logic       grant_en;
   logic [1:0] req;
   logic [1:0] gnt;
   logic       accept;
   logic       out_fire;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (accept),
      .gnt     (gnt)
   );

   // Handshake and shift control; everything is held quiet while reset is asserted.
   always_comb begin
      shift_ok    = !tv_q[DEPTH-1] || out_ready;
      grant_en    = !rst && (state_q != FLUSH) && shift_ok;
      req         = {b_valid, a_valid} & {2{grant_en}};
      a_ready     = gnt[0];
      b_ready     = gnt[1];
      accept      = gnt[0] || gnt[1];
      out_valid   = tv_q[DEPTH-1] && !rst;
      out_src     = ts_q[DEPTH-1];
      out_data    = sr_data_out;
      out_fire    = out_valid && out_ready;
      sr_shift_en = !rst && shift_ok &&
                    (accept || tv_q[DEPTH-1] || ((state_q == FLUSH) && (occ_q != '0)));
      sr_data_in  = gnt[1] ? b_data : (gnt[0] ? a_data : '0);
      occupancy   = occ_q;
      busy        = (state_q != IDLE);
   end

   // Tags follow the data line; occupancy counts live tags.
   always_comb begin
      tv_d  = tv_q;
      ts_d  = ts_q;
      if (sr_shift_en) begin
         tv_d = {tv_q[DEPTH-2:0], accept};
         ts_d = {ts_q[DEPTH-2:0], gnt[1]};
      end
      occ_d = occ_q + CW'(accept) - CW'(out_fire);
   end

   // FSM next state; a flush accepted in RUN takes any same-cycle insert with it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = RUN;
         end
         RUN: begin
            if (flush) begin
               state_d = FLUSH;
            end else if ((occ_d == '0) && !accept) begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            if (occ_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, tag and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tv_q    <= '0;
         ts_q    <= '0;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         tv_q    <= tv_d;
         ts_q    <= ts_d;
         occ_q   <= occ_d;
      end
   end

endmodule
